// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract/compare datapath: operation
// encoding and the packed flag bundle produced alongside every result.
package alu_pkg;

  // Operation codes as presented on in_op; OP_RSV executes as OP_ADD.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Flag bundle, MSB first: {cary, of, eq, zero, neg, lt_s, lt_u}.
  typedef struct packed {
    logic cary;
    logic of;
    logic eq;
    logic zero;
    logic neg;
    logic lt_s;
    logic lt_u;
  } flags_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor and flag generator.
// Optional feature: define ADDSUB_SAT_EN to clamp ADD/SUB results on signed
// overflow (flags still describe the raw, unclamped sum).
module addsub_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e                       op,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [WIDTH-1:0]   s,
  output flags_t                    flags
);

  localparam int MSB = WIDTH - 1;

`ifdef ADDSUB_SAT_EN
  // Clamp toward the sign of operand A when the signed result overflowed.
  function automatic logic signed [WIDTH-1:0] sat_fn(
    input logic signed [WIDTH-1:0] raw_v,
    input logic                    ovf,
    input logic                    a_msb
  );
    logic signed [WIDTH-1:0] r;
    r = raw_v;
    if (ovf) r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction
`endif

  logic                    is_sub;
  logic        [WIDTH-1:0] b_eff;
  logic        [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] raw;
  logic                    ovf;

  // Subtraction is a + ~b + 1; the same adder serves every operation.
  assign is_sub = (op == OP_SUB) || (op == OP_CMP);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign raw    = sum[MSB:0];
  assign ovf    = (a[MSB] == b_eff[MSB]) && (raw[MSB] != a[MSB]);

  // Result selection and flags; comparison flags always describe a vs b.
  always_comb begin
    flags      = '0;
    flags.cary = sum[WIDTH];
    flags.of   = ovf;
    flags.eq   = (a == b);
    flags.zero = (raw == '0);
    flags.neg  = raw[MSB];
    flags.lt_s = (a < b);
    flags.lt_u = ($unsigned(a) < $unsigned(b));
    if (op == OP_CMP) begin
      s = '0;
    end else begin
`ifdef ADDSUB_SAT_EN
      s = sat_fn(raw, ovf, a[MSB]);
`else
      s = raw;
`endif
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/subtract/compare unit with valid/ready on both
// sides. Stage 1 captures the operation, stage 2 holds result and flags.
// Optional feature: ADDSUB_SAT_EN (saturating ADD/SUB, see addsub_core).
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_cary,
  output logic             out_of,
  output logic             out_eq,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_lt_s,
  output logic             out_lt_u
);

  logic                    vld_p1, vld_p2;
  op_e                     op_p1;
  logic signed [WIDTH-1:0] a_p1, b_p1;
  logic        [TAG_W-1:0] tag_p1;
  logic signed [WIDTH-1:0] s_p2;
  logic        [TAG_W-1:0] tag_p2;
  flags_t                  flags_p2;

  logic                    s1_adv, s2_adv;
  logic signed [WIDTH-1:0] s_c;
  flags_t                  flags_c;

  // A stage may advance when empty or when its successor advances.
  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // Valid bits move with the stages; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: capture accepted operation ----
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      op_p1  <= op_e'(in_op);
      a_p1   <= in_a;
      b_p1   <= in_b;
      tag_p1 <= in_tag;
    end
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .op    (op_p1),
    .a     (a_p1),
    .b     (b_p1),
    .s     (s_c),
    .flags (flags_c)
  );

  // ---- stage 2: register result; held while downstream stalls ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s_p2     <= '0;
      tag_p2   <= '0;
      flags_p2 <= '0;
    end else if (s2_adv && vld_p1) begin
      s_p2     <= s_c;
      tag_p2   <= tag_p1;
      flags_p2 <= flags_c;
    end
  end

  assign out_valid = vld_p2;
  assign out_s     = s_p2;
  assign out_tag   = tag_p2;
  assign out_cary  = flags_p2.cary;
  assign out_of    = flags_p2.of;
  assign out_eq    = flags_p2.eq;
  assign out_zero  = flags_p2.zero;
  assign out_neg   = flags_p2.neg;
  assign out_lt_s  = flags_p2.lt_s;
  assign out_lt_u  = flags_p2.lt_u;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=32, TAG_W=4). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_addsub_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_s;
  logic [3:0]  out_tag;
  logic        out_cary, out_of, out_eq, out_zero, out_neg, out_lt_s, out_lt_u;
  logic [6:0]  flg;

  int n_chk = 0;
  int n_pass = 0;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  addsub_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_tag(out_tag),
    .out_cary(out_cary), .out_of(out_of), .out_eq(out_eq), .out_zero(out_zero),
    .out_neg(out_neg), .out_lt_s(out_lt_s), .out_lt_u(out_lt_u)
  );

  assign flg = {out_cary, out_of, out_eq, out_zero, out_neg, out_lt_s, out_lt_u};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One operation through an empty pipe; flags are {cary,of,eq,zero,neg,lt_s,lt_u}.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] exp_s, input logic [6:0] exp_f);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    #1;
    chk({name, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".lat"}, lat, 2);
    chk({name, ".s"}, out_s, exp_s);
    chk({name, ".tag"}, out_tag, tag);
    chk({name, ".flags"}, flg, exp_f);
  endtask

  initial begin
    int got, acc, dr, stale;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst0.vld", out_valid, 0);
    chk("rst0.s", out_s, 0);
    chk("rst0.tag", out_tag, 0);
    chk("rst0.flags", flg, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst0.rdy", in_ready, 1);

    // Directed arithmetic vectors
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'h1, 32'h0, 7'b1001010);
    do_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'h2,
          SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 7'b0100100);
    do_op("sub_neg",  OP_SUB, 32'd5, 32'd7, 4'h3, 32'hFFFF_FFFE, 7'b0000111);
    do_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1, 4'h4,
          SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 7'b1100010);
    do_op("cmp_eq",   OP_CMP, 32'h1234, 32'h1234, 4'h5, 32'h0, 7'b1011000);
    do_op("cmp_lt",   OP_CMP, 32'hFFFF_FFFF, 32'h1, 4'h6, 32'h0, 7'b1000110);
    do_op("rsv_add",  OP_RSV, 32'd3, 32'd4, 4'h7, 32'd7, 7'b0000011);
    do_op("sub_b0",   OP_SUB, 32'd9, 32'd0, 4'h8, 32'd9, 7'b1000000);
    do_op("add_novf", OP_ADD, 32'h8000_0000, 32'h8000_0000, 4'h9,
          SAT ? 32'h8000_0000 : 32'h0, 7'b1111000);

    // Back-to-back: 8 ops, one result per cycle, two cycles after accept
    got = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b.tag", out_tag, got);
        chk("b2b.cycle", k, got + 2);
        chk("b2b.s", out_s, 3 * got + 1);
        got++;
      end
      if (k < 8) begin
        in_valid = 1'b1; in_op = OP_ADD; in_a = 3 * k; in_b = 1; in_tag = k[3:0];
        #1;
        chk("b2b.rdy", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b.count", got, 8);

    // Stall: out_ready low, in_valid held; only two ops fit
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("stall.vld", out_valid, 1);
        chk("stall.s", out_s, 100);
        chk("stall.tag", out_tag, 10);
      end
      in_valid = 1'b1; in_op = OP_ADD; in_a = 100 + acc; in_b = acc; in_tag = 4'(10 + acc);
      #1;
      if (in_ready) acc++;
    end
    chk("stall.acc", acc, 2);
    chk("stall.rdy", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    dr = 0;
    for (int j = 0; j < 6; j++) begin
      if (out_valid) begin
        chk("drain.tag", out_tag, 10 + dr);
        chk("drain.s", out_s, 100 + 2 * dr);
        dr++;
      end
      @(negedge clk);
    end
    chk("drain.count", dr, 2);

    // Reset with two ops in flight
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 5; in_b = 6; in_tag = 4'h5;
    @(negedge clk);
    in_a = 7; in_b = 8; in_tag = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst.vld", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst1.vld", out_valid, 0);
    chk("rst1.s", out_s, 0);
    chk("rst1.tag", out_tag, 0);
    chk("rst1.flags", flg, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst1.rdy", in_ready, 1);
    stale = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst1.stale", stale, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
